// File: rtl/eee_bbox_pkg.sv
// Shared definitions for the colour bounding-box block: packet-type codes,
// overlay colour table, coordinate width helper and the packet FSM states.
package eee_bbox_pkg;

    // Low nibble of the first beat of a packet identifies its type.
    localparam logic [3:0] PKT_VIDEO = 4'h0;
    localparam logic [3:0] PKT_CTRL  = 4'hF;

    localparam int MAX_CLASSES = 8;

    // Colour painted on the perimeter of class k's box when overlay is on.
    localparam logic [23:0] OVL_COLOUR [MAX_CLASSES] = '{
        24'hFF0000,  // class 0: red
        24'h00FF00,  // class 1: green
        24'h0000FF,  // class 2: blue
        24'hFFFF00,  // class 3: yellow
        24'h00FFFF,  // class 4: cyan
        24'hFF00FF,  // class 5: magenta
        24'hFFFFFF,  // class 6: white
        24'hFF8000   // class 7: orange
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VIDEO = 2'd1,
        ST_OTHER = 2'd2
    } state_t;

    // Bits needed for an x or y coordinate; never less than one.
    function automatic int coord_w(input int w, input int h);
        int m;
        int n;
        m = (w > h) ? w : h;
        n = $clog2(m);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/eee_colour_match.sv
// Per-pixel colour class test: every RGB channel must sit inside the
// inclusive [lo, hi] window. Purely combinational.
module eee_colour_match (
    input  logic [23:0] pixel,
    input  logic [23:0] lo,
    input  logic [23:0] hi,
    output logic        match
);

    logic [2:0] in_range;

    // Channel-wise window compare (B = bits 7:0, G = 15:8, R = 23:16).
    always_comb begin
        in_range = '0;
        for (int c = 0; c < 3; c++) begin
            in_range[c] = (pixel[8*c +: 8] >= lo[8*c +: 8]) &&
                          (pixel[8*c +: 8] <= hi[8*c +: 8]);
        end
        match = &in_range;
    end

endmodule

// File: rtl/eee_colour_bbox.sv
// Colour bounding-box tracker on an Avalon-ST video stream.
// Every beat passes through one output register stage. Pixels of video
// packets are matched against NUM_CLASSES RGB windows; per-class min/max
// coordinates are published on bbox_out at the end of each video frame.
// Optional feature: define EEE_BBOX_OVERLAY_EN to paint the perimeter of the
// previously published boxes into the output video when mode=1. Without it
// the video path is a bit-exact passthrough and mode is ignored.
//
// Handshake: a beat moves on a port when valid & ready are both high at the
// rising edge; a stalled source keeps data/sop/eop stable, and the sink is
// ready whenever the output register is empty or being drained.
module eee_colour_bbox
    import eee_bbox_pkg::*;
#(
    parameter  int IMAGE_W     = 640,
    parameter  int IMAGE_H     = 480,
    parameter  int NUM_CLASSES = 4,
    localparam int CW          = coord_w(IMAGE_W, IMAGE_H)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        mode,
    input  logic [NUM_CLASSES*24-1:0]   thr_lo,
    input  logic [NUM_CLASSES*24-1:0]   thr_hi,
    input  logic [23:0]                 sink_data,
    input  logic                        sink_valid,
    output logic                        sink_ready,
    input  logic                        sink_startofpacket,
    input  logic                        sink_endofpacket,
    output logic [23:0]                 source_data,
    output logic                        source_valid,
    input  logic                        source_ready,
    output logic                        source_startofpacket,
    output logic                        source_endofpacket,
    output logic [NUM_CLASSES*4*CW-1:0] bbox_out,
    output logic [NUM_CLASSES-1:0]      bbox_found,
    output logic                        bbox_valid,
    output logic [1:0]                  dbg_state
);

    state_t state_q, state_d;

    logic accept;
    logic hdr_video;
    logic pix_beat;
    logic frame_end;
    logic [23:0] pix_out;

    logic [CW-1:0] x_q, y_q;
    logic [NUM_CLASSES-1:0] match_vec;

    logic [NUM_CLASSES-1:0] acc_found, nxt_found, pub_found;
    logic [CW-1:0] acc_xmin [NUM_CLASSES];
    logic [CW-1:0] acc_xmax [NUM_CLASSES];
    logic [CW-1:0] acc_ymin [NUM_CLASSES];
    logic [CW-1:0] acc_ymax [NUM_CLASSES];
    logic [CW-1:0] nxt_xmin [NUM_CLASSES];
    logic [CW-1:0] nxt_xmax [NUM_CLASSES];
    logic [CW-1:0] nxt_ymin [NUM_CLASSES];
    logic [CW-1:0] nxt_ymax [NUM_CLASSES];
    logic [CW-1:0] pub_xmin [NUM_CLASSES];
    logic [CW-1:0] pub_xmax [NUM_CLASSES];
    logic [CW-1:0] pub_ymin [NUM_CLASSES];
    logic [CW-1:0] pub_ymax [NUM_CLASSES];

    assign sink_ready = reset_n & (source_ready | ~source_valid);
    assign accept     = sink_valid & sink_ready;
    assign hdr_video  = (sink_data[3:0] == PKT_VIDEO);
    // Pixel beats: anything after the header inside a video packet.
    assign pix_beat   = accept & ~sink_startofpacket & (state_q == ST_VIDEO);
    // A header-only video packet still ends a (empty) frame.
    assign frame_end  = accept & sink_endofpacket &
                        (sink_startofpacket ? hdr_video : (state_q == ST_VIDEO));
    assign dbg_state  = state_q;
    assign bbox_found = pub_found;

    genvar g;
    generate
        for (g = 0; g < NUM_CLASSES; g++) begin : g_match
            eee_colour_match u_match (
                .pixel (sink_data),
                .lo    (thr_lo[24*g +: 24]),
                .hi    (thr_hi[24*g +: 24]),
                .match (match_vec[g])
            );
        end
    endgenerate

    // Packet FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Packet FSM next state: eop closes a packet, sop opens one by type.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (sink_endofpacket)        state_d = ST_IDLE;
            else if (sink_startofpacket) state_d = hdr_video ? ST_VIDEO : ST_OTHER;
        end
    end

    // Accumulator update for the current pixel: first hit seeds, later hits widen.
    always_comb begin
        nxt_found = acc_found;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            nxt_xmin[k] = acc_xmin[k];
            nxt_xmax[k] = acc_xmax[k];
            nxt_ymin[k] = acc_ymin[k];
            nxt_ymax[k] = acc_ymax[k];
            if (pix_beat && match_vec[k]) begin
                nxt_found[k] = 1'b1;
                if (!acc_found[k]) begin
                    nxt_xmin[k] = x_q;
                    nxt_xmax[k] = x_q;
                    nxt_ymin[k] = y_q;
                    nxt_ymax[k] = y_q;
                end else begin
                    if (x_q < acc_xmin[k]) nxt_xmin[k] = x_q;
                    if (x_q > acc_xmax[k]) nxt_xmax[k] = x_q;
                    if (y_q < acc_ymin[k]) nxt_ymin[k] = y_q;
                    if (y_q > acc_ymax[k]) nxt_ymax[k] = y_q;
                end
            end
        end
    end

    // Coordinates, accumulators and the published result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_q        <= '0;
            y_q        <= '0;
            acc_found  <= '0;
            pub_found  <= '0;
            bbox_valid <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                acc_xmin[k] <= '0; acc_xmax[k] <= '0;
                acc_ymin[k] <= '0; acc_ymax[k] <= '0;
                pub_xmin[k] <= '0; pub_xmax[k] <= '0;
                pub_ymin[k] <= '0; pub_ymax[k] <= '0;
            end
        end else begin
            bbox_valid <= 1'b0;
            if (frame_end) begin
                // Includes the eop pixel; a header-only frame publishes empty.
                bbox_valid <= 1'b1;
                pub_found  <= sink_startofpacket ? '0 : nxt_found;
                acc_found  <= '0;
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    pub_xmin[k] <= sink_startofpacket ? '0 : nxt_xmin[k];
                    pub_xmax[k] <= sink_startofpacket ? '0 : nxt_xmax[k];
                    pub_ymin[k] <= sink_startofpacket ? '0 : nxt_ymin[k];
                    pub_ymax[k] <= sink_startofpacket ? '0 : nxt_ymax[k];
                    acc_xmin[k] <= '0; acc_xmax[k] <= '0;
                    acc_ymin[k] <= '0; acc_ymax[k] <= '0;
                end
            end else if (accept && sink_startofpacket) begin
                acc_found <= '0;
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    acc_xmin[k] <= '0; acc_xmax[k] <= '0;
                    acc_ymin[k] <= '0; acc_ymax[k] <= '0;
                end
            end else if (pix_beat) begin
                acc_found <= nxt_found;
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    acc_xmin[k] <= nxt_xmin[k]; acc_xmax[k] <= nxt_xmax[k];
                    acc_ymin[k] <= nxt_ymin[k]; acc_ymax[k] <= nxt_ymax[k];
                end
            end

            if (accept && sink_startofpacket) begin
                x_q <= '0;
                y_q <= '0;
            end else if (pix_beat) begin
                if (x_q == CW'(IMAGE_W - 1)) begin
                    x_q <= '0;
                    if (y_q != CW'(IMAGE_H - 1)) y_q <= y_q + CW'(1);
                end else begin
                    x_q <= x_q + CW'(1);
                end
            end
        end
    end

    // Pack the published boxes as {xmin, xmax, ymin, ymax} per class.
    always_comb begin
        bbox_out = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            bbox_out[k*4*CW +: 4*CW] = {pub_xmin[k], pub_xmax[k], pub_ymin[k], pub_ymax[k]};
        end
    end

`ifdef EEE_BBOX_OVERLAY_EN
    logic        mode_q;
    logic        ovl_hit;
    logic [23:0] ovl_col;

    // Mode is frozen at each video header so a frame is drawn consistently.
    always_ff @(posedge clk) begin
        if (!reset_n)                                        mode_q <= 1'b0;
        else if (accept && sink_startofpacket && hdr_video)  mode_q <= mode;
    end

    // Perimeter overlay; scanning downwards leaves the lowest class on top.
    always_comb begin
        ovl_hit = 1'b0;
        ovl_col = '0;
        pix_out = sink_data;
        for (int k = NUM_CLASSES - 1; k >= 0; k--) begin
            if (pub_found[k] &&
                ((((x_q == pub_xmin[k]) || (x_q == pub_xmax[k])) &&
                  (y_q >= pub_ymin[k]) && (y_q <= pub_ymax[k])) ||
                 (((y_q == pub_ymin[k]) || (y_q == pub_ymax[k])) &&
                  (x_q >= pub_xmin[k]) && (x_q <= pub_xmax[k])))) begin
                ovl_hit = 1'b1;
                ovl_col = OVL_COLOUR[k];
            end
        end
        if (mode_q && ovl_hit && (state_q == ST_VIDEO) && !sink_startofpacket)
            pix_out = ovl_col;
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign pix_out     = sink_data;
`endif

    // Output register stage: load on accept, empty once the sink takes it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            source_valid         <= 1'b0;
            source_data          <= '0;
            source_startofpacket <= 1'b0;
            source_endofpacket   <= 1'b0;
        end else if (accept) begin
            source_valid         <= 1'b1;
            source_data          <= pix_out;
            source_startofpacket <= sink_startofpacket;
            source_endofpacket   <= sink_endofpacket;
        end else if (source_ready) begin
            source_valid         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eee_colour_bbox.sv
// Bench for eee_colour_bbox on a small 8x4 image with four colour classes.
module tb_eee_colour_bbox;
    import eee_bbox_pkg::*;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int NC = 4;
    localparam int CW = coord_w(W, H);
    localparam int BW = NC * 4 * CW;
`ifdef EEE_BBOX_OVERLAY_EN
    localparam bit OVL_ON = 1'b1;
`else
    localparam bit OVL_ON = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            mode = 1'b0;
    logic [NC*24-1:0] thr_lo = '0;
    logic [NC*24-1:0] thr_hi = '0;
    logic [23:0]     sink_data = '0;
    logic            sink_valid = 1'b0;
    logic            sink_sop = 1'b0;
    logic            sink_eop = 1'b0;
    logic            sink_ready;
    logic [23:0]     source_data;
    logic            source_valid;
    logic            source_ready = 1'b1;
    logic            source_sop;
    logic            source_eop;
    logic [BW-1:0]   bbox_out;
    logic [NC-1:0]   bbox_found;
    logic            bbox_valid;
    logic [1:0]      dbg_state;
    logic            rand_rdy = 1'b0;

    always #5 clk = ~clk;

    eee_colour_bbox #(.IMAGE_W(W), .IMAGE_H(H), .NUM_CLASSES(NC)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .mode                 (mode),
        .thr_lo               (thr_lo),
        .thr_hi               (thr_hi),
        .sink_data            (sink_data),
        .sink_valid           (sink_valid),
        .sink_ready           (sink_ready),
        .sink_startofpacket   (sink_sop),
        .sink_endofpacket     (sink_eop),
        .source_data          (source_data),
        .source_valid         (source_valid),
        .source_ready         (source_ready),
        .source_startofpacket (source_sop),
        .source_endofpacket   (source_eop),
        .bbox_out             (bbox_out),
        .bbox_found           (bbox_found),
        .bbox_valid           (bbox_valid),
        .dbg_state            (dbg_state)
    );

    // Output back-pressure: always ready, or a coin flip every cycle.
    always @(posedge clk) begin
        #1;
        source_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [25:0]   exp_q[$];        // {sop, eop, data}
    logic [BW-1:0] exp_bbox_q[$];
    logic [NC-1:0] exp_found_q[$];

    // Reference view of the currently published boxes (drives overlay model).
    logic [NC-1:0] pub_found = '0;
    int pub_xmin[NC], pub_xmax[NC], pub_ymin[NC], pub_ymax[NC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit px_match(input int k, input logic [23:0] p);
        logic [23:0] lo, hi;
        lo = thr_lo[k*24 +: 24];
        hi = thr_hi[k*24 +: 24];
        return (p[23:16] >= lo[23:16]) && (p[23:16] <= hi[23:16]) &&
               (p[15:8]  >= lo[15:8])  && (p[15:8]  <= hi[15:8])  &&
               (p[7:0]   >= lo[7:0])   && (p[7:0]   <= hi[7:0]);
    endfunction

    function automatic logic [23:0] model_out(input logic [23:0] p, input int x, input int y, input bit md);
        if (OVL_ON && md) begin
            for (int k = 0; k < NC; k++) begin
                if (pub_found[k]) begin
                    bit on_v, on_h;
                    on_v = (x == pub_xmin[k] || x == pub_xmax[k]) && y >= pub_ymin[k] && y <= pub_ymax[k];
                    on_h = (y == pub_ymin[k] || y == pub_ymax[k]) && x >= pub_xmin[k] && x <= pub_xmax[k];
                    if (on_v || on_h) return OVL_COLOUR[k];
                end
            end
        end
        return p;
    endfunction

    function automatic logic [23:0] rand_pix();
        case ($urandom_range(0, 5))
            0:       return 24'hFF0000;
            1:       return 24'h00FF00;
            2:       return 24'h606070;
            3:       return 24'h1010A0;
            4:       return 24'h000000;
            default: return 24'($urandom());
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [23:0] d, input logic s, input logic e, input logic [23:0] expd);
        int guard;
        guard = 0;
        sink_data = d; sink_sop = s; sink_eop = e; sink_valid = 1'b1;
        @(negedge clk);
        while (!sink_ready) begin
            guard++;
            if (guard > 1000) begin
                n_vec++; n_err++;
                $display("FAIL sink_ready_timeout: got 0 expected 1 at %0t", $time);
                sink_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        exp_q.push_back({s, e, expd});
        @(posedge clk);
        #1;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state();
        check("rst_sink_ready",   sink_ready,   0);
        check("rst_source_valid", source_valid, 0);
        check("rst_source_sop",   source_sop,   0);
        check("rst_source_eop",   source_eop,   0);
        check("rst_source_data",  source_data,  0);
        check("rst_bbox_out",     bbox_out,     0);
        check("rst_bbox_found",   bbox_found,   0);
        check("rst_bbox_valid",   bbox_valid,   0);
    endtask

    // Reset mid-stream: whatever sits in the output register is lost.
    task automatic do_reset();
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state();
        exp_q.delete();
        pub_found = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Video frame: header + pixels. abort_after > 0 resets after that many pixels.
    task automatic send_frame(input logic [23:0] pix[$], input bit md, input bit flip_mode, input int abort_after);
        logic [23:0]   hdr;
        logic [NC-1:0] f;
        logic [BW-1:0] eb;
        int xmn[NC], xmx[NC], ymn[NC], ymx[NC];
        int n, x, y;
        n = pix.size();
        f = '0;
        hdr = 24'($urandom());
        hdr[3:0] = PKT_VIDEO;
        mode = md;
        drive_beat(hdr, 1'b1, 1'b0, hdr);
        if (flip_mode) mode = ~md;
        for (int i = 0; i < n; i++) begin
            x = i % W;
            y = (i / W < H - 1) ? i / W : H - 1;
            for (int k = 0; k < NC; k++) begin
                if (px_match(k, pix[i])) begin
                    if (!f[k]) begin
                        xmn[k] = x; xmx[k] = x; ymn[k] = y; ymx[k] = y;
                    end else begin
                        if (x < xmn[k]) xmn[k] = x;
                        if (x > xmx[k]) xmx[k] = x;
                        if (y < ymn[k]) ymn[k] = y;
                        if (y > ymx[k]) ymx[k] = y;
                    end
                    f[k] = 1'b1;
                end
            end
            if (i == n - 1) begin
                eb = '0;
                for (int k = 0; k < NC; k++)
                    if (f[k]) eb[k*4*CW +: 4*CW] = {CW'(xmn[k]), CW'(xmx[k]), CW'(ymn[k]), CW'(ymx[k])};
                exp_bbox_q.push_back(eb);
                exp_found_q.push_back(f);
            end
            drive_beat(pix[i], 1'b0, i == n - 1, model_out(pix[i], x, y, md));
            if (abort_after > 0 && i + 1 == abort_after) begin
                do_reset();
                return;
            end
        end
        pub_found = f;
        for (int k = 0; k < NC; k++) begin
            pub_xmin[k] = xmn[k]; pub_xmax[k] = xmx[k];
            pub_ymin[k] = ymn[k]; pub_ymax[k] = ymx[k];
        end
    endtask

    task automatic send_ctrl(input int nbeats);
        logic [23:0] d;
        for (int i = 0; i < nbeats; i++) begin
            d = 24'($urandom());
            if (i == 0) d[3:0] = PKT_CTRL;
            drive_beat(d, i == 0, i == nbeats - 1, d);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (source_valid && source_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_beat: got 0x%0h expected none", source_data);
                end else begin
                    check("video_beat", {source_sop, source_eop, source_data}, exp_q.pop_front());
                end
            end
            if (bbox_valid) begin
                if (exp_bbox_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL spurious_bbox_valid: got 1 expected 0 at %0t", $time);
                end else begin
                    check("bbox_out",   bbox_out,   exp_bbox_q.pop_front());
                    check("bbox_found", bbox_found, exp_found_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [23:0] pix[$];

    initial begin
        // class0 pure red, class1 greenish, class2 grey band, class3 dark blue
        thr_lo[0*24 +: 24] = 24'hFF0000; thr_hi[0*24 +: 24] = 24'hFF0000;
        thr_lo[1*24 +: 24] = 24'h00E000; thr_hi[1*24 +: 24] = 24'h20FF20;
        thr_lo[2*24 +: 24] = 24'h404040; thr_hi[2*24 +: 24] = 24'h8080C0;
        thr_lo[3*24 +: 24] = 24'h000080; thr_hi[3*24 +: 24] = 24'h3030FF;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Red at (2,1) and (5,3): class0 box {2,5,1,3}
        pix.delete();
        for (int i = 0; i < W * H; i++) pix.push_back(24'h000000);
        pix[1*W + 2] = 24'hFF0000;
        pix[3*W + 5] = 24'hFF0000;
        send_frame(pix, 1'b0, 1'b0, 0);

        // No matching pixel at all
        pix.delete();
        for (int i = 0; i < W * H; i++) pix.push_back(24'h000000);
        send_frame(pix, 1'b0, 1'b0, 0);

        // Control packet between frames
        send_ctrl(3);

        // Green at (1,0) and (3,2): class1 box {1,3,0,2}
        pix.delete();
        for (int i = 0; i < W * H; i++) pix.push_back(24'h000000);
        pix[0*W + 1] = 24'h00FF00;
        pix[2*W + 3] = 24'h00FF00;
        send_frame(pix, 1'b0, 1'b0, 0);

        // Overlay frame; mode flips mid-frame but stays latched
        pix.delete();
        for (int i = 0; i < W * H; i++) pix.push_back(24'($urandom()) | 24'h000100);
        send_frame(pix, 1'b1, 1'b1, 0);

        // Random back-pressure, random frames/lengths, including short and over-long
        rand_rdy = 1'b1;
        for (int f = 0; f < 12; f++) begin
            pix.delete();
            for (int i = 0; i < $urandom_range(1, 44); i++) pix.push_back(rand_pix());
            send_frame(pix, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            if (f % 4 == 1) send_ctrl(3);
        end

        // Reset after 10 pixels of a frame, then a clean frame
        pix.delete();
        for (int i = 0; i < W * H; i++) pix.push_back(rand_pix());
        exp_bbox_q.push_back('0);   // provisional entry, popped again after the abort
        exp_found_q.push_back('0);
        send_frame(pix, 1'b0, 1'b0, 10);
        // Aborted frame never reached eop; drop the provisional pair.
        void'(exp_bbox_q.pop_back());
        void'(exp_found_q.pop_back());

        pix.delete();
        for (int i = 0; i < W * H; i++) pix.push_back(24'h000000);
        pix[1*W + 2] = 24'hFF0000;
        pix[3*W + 5] = 24'hFF0000;
        pix[0*W + 1] = 24'h00FF00;
        pix[2*W + 3] = 24'h00FF00;
        send_frame(pix, 1'b1, 1'b0, 0);

        pix.delete();
        for (int i = 0; i < W * H; i++) pix.push_back(rand_pix());
        send_frame(pix, 1'b1, 1'b0, 0);

        // Drain
        rand_rdy = 1'b0;
        for (int i = 0; i < 500 && (exp_q.size() != 0 || exp_bbox_q.size() != 0); i++)
            @(posedge clk);
        repeat (4) @(posedge clk);
        check("drain_video_q", exp_q.size(), 0);
        check("drain_bbox_q",  exp_bbox_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/eee_colour_bbox.md
EEE_COLOUR_BBOX -- requirements
Module: eee_colour_bbox

Interface
REQ-001 Parameter IMAGE_W, 640, active pixels per line.
REQ-002 Parameter IMAGE_H, 480, active lines per frame.
REQ-003 Parameter NUM_CLASSES, 4, number of independent colour classes (1..8).
REQ-004 Port clk  in  1  sole clock; all logic rising-edge.
REQ-005 Port reset_n  in  1  synchronous active-low reset.
REQ-006 Port mode  in  1  0 = passthrough, 1 = draw boxes on output video.
REQ-007 Port thr_lo / thr_hi  in  NUM_CLASSES*24 each  per-class inclusive RGB bounds, class k at [24k+23:24k].
REQ-008 Port sink_data/valid/ready/startofpacket/endofpacket  in/in/out/in/in  24/1/1/1/1  Avalon-ST video input.
REQ-009 Port source_data/valid/ready/startofpacket/endofpacket  out/out/in/out/out  24/1/1/1/1  Avalon-ST video output.
REQ-010 Port bbox_out  out  NUM_CLASSES*4*CW  per class {xmin,xmax,ymin,ymax}, CW = clog2(max(IMAGE_W,IMAGE_H)).
REQ-011 Port bbox_found  out  NUM_CLASSES  class k had at least one matching pixel in last frame.
REQ-012 Port bbox_valid  out  1  one-cycle pulse when bbox_out/bbox_found update.

Function
REQ-013 Single output register stage; latency exactly 1 accepted beat; sink_ready = source_ready | ~source_valid.
REQ-014 Beat transfers only when valid & ready; stalled source holds data/sop/eop stable.
REQ-015 FSM states IDLE, VIDEO, OTHER; IDLE->VIDEO on sop beat with data[3:0]==0, IDLE->OTHER on sop beat with data[3:0]!=0.
REQ-016 VIDEO/OTHER->IDLE on eop beat; sop beat in any state restarts per REQ-015 and discards partial accumulators.
REQ-017 All packets pass through; only VIDEO non-header beats are counted, matched or overlaid.
REQ-018 x counter 0..IMAGE_W-1 wraps to 0 and increments y; y saturates at IMAGE_H-1; both clear on sop.
REQ-019 Pixel matches class k when each of R,G,B lies within [thr_lo,thr_hi] inclusive for that channel.
REQ-020 Per class accumulator: first match loads min=max=(x,y); later matches widen min/max.
REQ-021 On VIDEO eop beat (including short frame), accumulators copy to bbox_out/bbox_found next cycle, bbox_valid pulses, accumulators clear.
REQ-022 Match on the eop beat itself is included in the published result.
REQ-023 Overlay (mode=1): pixel on perimeter of published box k with found[k]=1 is replaced by OVL_COLOUR[k]; lowest k wins.
REQ-024 mode sampled at each VIDEO sop; mid-frame changes take effect next frame.

Reset
REQ-025 reset_n=0 at rising clk: FSM IDLE, source_valid 0, sop/eop 0, source_data 0, bbox_out 0, bbox_found 0, bbox_valid 0, counters and accumulators 0.
REQ-026 Reset mid-frame drops in-flight beat; no bbox_valid pulse for that frame.
REQ-027 sink_ready is 0 while reset_n=0.

Configuration
REQ-028 Macro EEE_BBOX_OVERLAY_EN defined: REQ-023/024 overlay logic present.
REQ-029 Macro undefined: no overlay logic, mode ignored, video data bit-exact passthrough; bounding box outputs unchanged.

Structure
REQ-030 Package eee_bbox_pkg holds packet-type constants, OVL_COLOUR table (8 x 24-bit), coord width function and FSM state typedef.
REQ-031 Sub-module eee_colour_match: combinational per-pixel threshold compare, instantiated NUM_CLASSES times.

Verification
REQ-032 IMAGE_W=8, IMAGE_H=4, class0 thr 0xFF0000..0xFF0000; red at (2,1),(5,3) -> bbox_valid pulse, class0 {2,5,1,3}, found=1.
REQ-033 Frame with no matching pixels -> found=0, bbox_out for that class 0, bbox_valid still pulses once.
REQ-034 Control packet (header 0xF) of 3 beats between frames -> passed unmodified, no bbox_valid, counters untouched.
REQ-035 source_ready toggled 50% random over full frame -> output beat sequence identical to input, no loss or duplication.
REQ-036 mode=1, prior box class1 {1,3,0,2} -> output pixels on perimeter equal OVL_COLOUR[1], interior/outside unchanged.
REQ-037 reset_n=0 at beat 10 of a frame, then new frame -> no pulse for aborted frame, correct result for new frame.
